// File: rtl/memory_access_stage_pkg.sv
// Shared definitions for the memory access stage: FSM state encoding,
// register-index width and the W-stage control bundle with its bubble value.
package memory_access_stage_pkg;

  // Data-memory handshake FSM states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_ABORT = 2'd2
  } mem_state_e;

  // Width of a register-file index
  localparam int REG_IDX_W = 4;

  // Control bits carried into the writeback stage
  typedef struct packed {
    logic pcsrc;
    logic regwrite;
    logic memtoreg;
  } wb_ctrl_t;

  // Control value of an empty slot: no PC redirect, no register write
  localparam wb_ctrl_t BUBBLE_CTRL = 3'b000;

endpackage

// File: rtl/memory_access_stage_mem_wb_reg.sv
// Memory-to-writeback pipeline register. On load it captures the M-stage
// fields (read data only for loads); on bubble it clears the control bits
// and holds the data fields so the previous instruction is not written twice.
module mem_wb_reg
  import memory_access_stage_pkg::*;
#(
  parameter int W = 32
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 load,
  input  logic                 bubble,
  input  logic                 capture_rdata,
  input  wb_ctrl_t             ctrl_in,
  input  logic [W-1:0]         rdata_in,
  input  logic [W-1:0]         alu_in,
  input  logic [REG_IDX_W-1:0] wa3_in,
  output wb_ctrl_t             ctrl_out,
  output logic [W-1:0]         read_data,
  output logic [W-1:0]         alu_out,
  output logic [REG_IDX_W-1:0] wa3_out
);

  wb_ctrl_t             ctrl_r;
  logic [W-1:0]         read_data_r;
  logic [W-1:0]         alu_out_r;
  logic [REG_IDX_W-1:0] wa3_r;

  // Pipeline register: load new instruction, insert bubble, or hold
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl_r      <= BUBBLE_CTRL;
      read_data_r <= {W{1'b0}};
      alu_out_r   <= {W{1'b0}};
      wa3_r       <= {REG_IDX_W{1'b0}};
    end else if (load) begin
      ctrl_r    <= ctrl_in;
      alu_out_r <= alu_in;
      wa3_r     <= wa3_in;
      if (capture_rdata) begin
        read_data_r <= rdata_in;
      end else begin
        read_data_r <= read_data_r;
      end
    end else if (bubble) begin
      ctrl_r <= BUBBLE_CTRL;
    end else begin
      ctrl_r <= ctrl_r;
    end
  end

  assign ctrl_out  = ctrl_r;
  assign read_data = read_data_r;
  assign alu_out   = alu_out_r;
  assign wa3_out   = wa3_r;

endmodule

// File: rtl/memory_access_stage.sv
// Memory stage: drives the data-memory req/ack handshake, stalls the front of
// the pipeline while an access is pending and owns the M/W pipeline register.
// Optional feature macro: MEM_TIMEOUT_EN adds a wait counter that aborts an
// access after TIMEOUT wait cycles and raises the sticky mem_fault flag.
module memory_access_stage
  import memory_access_stage_pkg::*;
#(
  parameter int W       = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 PCSrcM,
  input  logic                 RegWriteM,
  input  logic                 MemWriteM,
  input  logic                 MemtoRegM,
  input  logic [W-1:0]         AluResultM,
  input  logic [W-1:0]         WriteDataM,
  input  logic [REG_IDX_W-1:0] WA3M,
  output logic                 dmem_req,
  output logic                 dmem_we,
  output logic [W-1:0]         dmem_addr,
  output logic [W-1:0]         dmem_wdata,
  input  logic                 dmem_ack,
  input  logic [W-1:0]         dmem_rdata,
  output logic                 StallM,
  output logic                 PCSrcW,
  output logic                 RegWriteW,
  output logic                 MemtoRegW,
  output logic [W-1:0]         ReadDataW,
  output logic [W-1:0]         AluOutW,
  output logic [REG_IDX_W-1:0] WA3W,
  output logic                 mem_fault
);

  mem_state_e state_r;
  mem_state_e state_next_s;
  logic       access_s;
  logic       is_load_s;
  logic       req_s;
  logic       stall_s;
  logic       wb_load_s;
  logic       wb_bubble_s;
  logic       timeout_s;
  wb_ctrl_t   ctrl_m_s;
  wb_ctrl_t   ctrl_w_s;

  // A simultaneous store/load request is resolved as a store
  assign access_s  = MemWriteM | MemtoRegM;
  assign is_load_s = MemtoRegM & ~MemWriteM;

  assign dmem_we    = MemWriteM;
  assign dmem_addr  = AluResultM;
  assign dmem_wdata = WriteDataM;
  assign dmem_req   = req_s;
  assign StallM     = stall_s;

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] wait_cnt_r;
  logic             fault_r;

  // Last allowed wait cycle reached without an ack
  assign timeout_s = (wait_cnt_r == CNT_W'(TIMEOUT - 1));

  // Wait-cycle counter: runs while staying in WAIT, clears otherwise
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wait_cnt_r <= {CNT_W{1'b0}};
    end else if ((state_r == ST_WAIT) && (state_next_s == ST_WAIT)) begin
      wait_cnt_r <= wait_cnt_r + CNT_W'(1);
    end else begin
      wait_cnt_r <= {CNT_W{1'b0}};
    end
  end

  // Sticky fault flag, set when an access is aborted
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fault_r <= 1'b0;
    end else if (state_next_s == ST_ABORT) begin
      fault_r <= 1'b1;
    end else begin
      fault_r <= fault_r;
    end
  end

  assign mem_fault = fault_r;
`else
  assign timeout_s = 1'b0;
  assign mem_fault = 1'b0;
`endif

  // FSM state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (access_s && !dmem_ack) begin
          state_next_s = ST_WAIT;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (dmem_ack) begin
          state_next_s = ST_IDLE;
        end else if (timeout_s) begin
          state_next_s = ST_ABORT;
        end else begin
          state_next_s = ST_WAIT;
        end
      end
      ST_ABORT: begin
        state_next_s = ST_IDLE;
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // FSM outputs: request, stall and W-register load/bubble selection
  always_comb begin
    req_s       = 1'b0;
    stall_s     = 1'b0;
    wb_load_s   = 1'b0;
    wb_bubble_s = 1'b1;
    case (state_r)
      ST_IDLE, ST_WAIT: begin
        req_s       = access_s;
        stall_s     = access_s & ~dmem_ack;
        wb_load_s   = ~(access_s & ~dmem_ack);
        wb_bubble_s = access_s & ~dmem_ack;
      end
      ST_ABORT: begin
        // Faulting instruction retires as a bubble; upstream advances
        req_s       = 1'b0;
        stall_s     = 1'b0;
        wb_load_s   = 1'b0;
        wb_bubble_s = 1'b1;
      end
      default: begin
        req_s       = 1'b0;
        stall_s     = 1'b0;
        wb_load_s   = 1'b0;
        wb_bubble_s = 1'b1;
      end
    endcase
  end

  assign ctrl_m_s.pcsrc    = PCSrcM;
  assign ctrl_m_s.regwrite = RegWriteM;
  assign ctrl_m_s.memtoreg = MemtoRegM;

  mem_wb_reg #(
    .W (W)
  ) u_mem_wb_reg (
    .clk           (clk),
    .reset_n       (reset_n),
    .load          (wb_load_s),
    .bubble        (wb_bubble_s),
    .capture_rdata (is_load_s),
    .ctrl_in       (ctrl_m_s),
    .rdata_in      (dmem_rdata),
    .alu_in        (AluResultM),
    .wa3_in        (WA3M),
    .ctrl_out      (ctrl_w_s),
    .read_data     (ReadDataW),
    .alu_out       (AluOutW),
    .wa3_out       (WA3W)
  );

  assign PCSrcW    = ctrl_w_s.pcsrc;
  assign RegWriteW = ctrl_w_s.regwrite;
  assign MemtoRegW = ctrl_w_s.memtoreg;

endmodule

// File: tb/tb_memory_access_stage.sv
// Scoreboard bench for memory_access_stage. Stimulus pushes one expectation
// per cycle; a monitor checks the combinational outputs on the falling edge
// of that cycle and the W register on the falling edge of the next one.
module tb_memory_access_stage;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        PCSrcM, RegWriteM, MemWriteM, MemtoRegM;
  logic [31:0] AluResultM, WriteDataM;
  logic [3:0]  WA3M;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic        StallM;
  logic        PCSrcW, RegWriteW, MemtoRegW;
  logic [31:0] ReadDataW, AluOutW;
  logic [3:0]  WA3W;
  logic        mem_fault;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  memory_access_stage #(.W(32), .TIMEOUT(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .PCSrcM(PCSrcM), .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .MemtoRegM(MemtoRegM),
    .AluResultM(AluResultM), .WriteDataM(WriteDataM), .WA3M(WA3M),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .StallM(StallM), .PCSrcW(PCSrcW), .RegWriteW(RegWriteW), .MemtoRegW(MemtoRegW),
    .ReadDataW(ReadDataW), .AluOutW(AluOutW), .WA3W(WA3W), .mem_fault(mem_fault)
  );

  // c = {pcsrc, regwrite, memwrite, memtoreg}; ew = {pcsrcW, regwriteW, memtoregW}
  typedef struct {
    logic [3:0]  c;
    logic [31:0] alu, wd;
    logic [3:0]  wa3;
    logic        ack;
    logic [31:0] rd;
    logic        es, ereq, ewe, ef, chk_w;
    logic [2:0]  ew;
    logic [31:0] erd, ealu;
    logic [3:0]  ewa3;
  } vec_t;

  vec_t q[$];
  vec_t pend;
  bit   pend_valid = 1'b0;

  function automatic vec_t mk(input logic [3:0] c, input logic [31:0] alu, input logic [31:0] wd,
                              input logic [3:0] wa3, input logic ack, input logic [31:0] rd,
                              input logic [2:0] srw, input logic ef, input logic [2:0] ew,
                              input logic [31:0] erd, input logic [31:0] ealu, input logic [3:0] ewa3);
    vec_t v;
    v.c = c; v.alu = alu; v.wd = wd; v.wa3 = wa3; v.ack = ack; v.rd = rd;
    v.es = srw[2]; v.ereq = srw[1]; v.ewe = srw[0]; v.ef = ef; v.chk_w = 1'b1;
    v.ew = ew; v.erd = erd; v.ealu = ealu; v.ewa3 = ewa3;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic apply(input vec_t v);
    @(posedge clk);
    #1;
    {PCSrcM, RegWriteM, MemWriteM, MemtoRegM} = v.c;
    AluResultM = v.alu; WriteDataM = v.wd; WA3M = v.wa3;
    dmem_ack = v.ack; dmem_rdata = v.rd;
    q.push_back(v);
  endtask

  task automatic clear_inputs();
    {PCSrcM, RegWriteM, MemWriteM, MemtoRegM} = 4'b0000;
    AluResultM = 32'h0; WriteDataM = 32'h0; WA3M = 4'h0;
    dmem_ack = 1'b0; dmem_rdata = 32'h0;
  endtask

  // Monitor: compares the DUT against the queued expectations
  initial begin
    vec_t e;
    forever begin
      @(negedge clk);
      if (pend_valid) begin
        chk("ctrl_w",   {29'd0, PCSrcW, RegWriteW, MemtoRegW}, {29'd0, pend.ew});
        chk("readdata", ReadDataW, pend.erd);
        chk("aluout",   AluOutW, pend.ealu);
        chk("wa3w",     {28'd0, WA3W}, {28'd0, pend.ewa3});
        pend_valid = 1'b0;
      end
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("stall",     {31'd0, StallM},    {31'd0, e.es});
        chk("dmem_req",  {31'd0, dmem_req},  {31'd0, e.ereq});
        chk("dmem_we",   {31'd0, dmem_we},   {31'd0, e.ewe});
        chk("mem_fault", {31'd0, mem_fault}, {31'd0, e.ef});
        if (e.ereq) begin
          chk("dmem_addr",  dmem_addr, e.alu);
          chk("dmem_wdata", dmem_wdata, e.wd);
        end
        if (e.chk_w) begin
          pend = e;
          pend_valid = 1'b1;
        end
      end
    end
  end

  // Stimulus
  initial begin
    vec_t v;
    clear_inputs();
    reset_n = 1'b0;
    #3;
    chk("rst_ctrl_w",  {29'd0, PCSrcW, RegWriteW, MemtoRegW}, 32'd0);
    chk("rst_rdata",   ReadDataW, 32'd0);
    chk("rst_aluout",  AluOutW, 32'd0);
    chk("rst_wa3",     {28'd0, WA3W}, 32'd0);
    chk("rst_req",     {31'd0, dmem_req}, 32'd0);
    chk("rst_stall",   {31'd0, StallM}, 32'd0);
    chk("rst_fault",   {31'd0, mem_fault}, 32'd0);
    #9 reset_n = 1'b1;

    //        c       alu           wd            wa3   ack   rd            s/r/w   f     ew      erd           ealu          ewa3
    apply(mk(4'b0000, 32'h0,        32'h0,        4'd0, 1'b0, 32'h0,        3'b000, 1'b0, 3'b000, 32'h0,        32'h0,        4'd0));
    apply(mk(4'b0100, 32'h1234,     32'h0,        4'd5, 1'b0, 32'h0,        3'b000, 1'b0, 3'b010, 32'h0,        32'h1234,     4'd5));
    apply(mk(4'b0101, 32'h40,       32'h0,        4'd6, 1'b1, 32'hDEADBEEF, 3'b010, 1'b0, 3'b011, 32'hDEADBEEF, 32'h40,       4'd6));
    for (int i = 0; i < 3; i++)
      apply(mk(4'b0010, 32'h80,     32'hA5A5A5A5, 4'd0, 1'b0, 32'h0,        3'b111, 1'b0, 3'b000, 32'hDEADBEEF, 32'h40,       4'd6));
    apply(mk(4'b0010, 32'h80,       32'hA5A5A5A5, 4'd0, 1'b1, 32'h0,        3'b011, 1'b0, 3'b000, 32'hDEADBEEF, 32'h80,       4'd0));
    apply(mk(4'b1000, 32'h100,      32'h0,        4'd0, 1'b0, 32'h0,        3'b000, 1'b0, 3'b100, 32'hDEADBEEF, 32'h100,      4'd0));
    apply(mk(4'b0101, 32'h44,       32'h0,        4'd1, 1'b0, 32'h11111111, 3'b110, 1'b0, 3'b000, 32'hDEADBEEF, 32'h100,      4'd0));
    apply(mk(4'b0101, 32'h44,       32'h0,        4'd1, 1'b1, 32'hCAFE0001, 3'b010, 1'b0, 3'b011, 32'hCAFE0001, 32'h44,       4'd1));
    apply(mk(4'b0101, 32'h48,       32'h0,        4'd2, 1'b0, 32'h22222222, 3'b110, 1'b0, 3'b000, 32'hCAFE0001, 32'h44,       4'd1));
    apply(mk(4'b0101, 32'h48,       32'h0,        4'd2, 1'b1, 32'hCAFE0002, 3'b010, 1'b0, 3'b011, 32'hCAFE0002, 32'h48,       4'd2));
    // Ack with no request is ignored
    apply(mk(4'b0100, 32'h10,       32'h0,        4'd3, 1'b1, 32'h99999999, 3'b000, 1'b0, 3'b010, 32'hCAFE0002, 32'h10,       4'd3));
    // Store and load flags together behave as a store
    apply(mk(4'b0111, 32'h90,       32'h5,        4'd4, 1'b1, 32'h77777777, 3'b011, 1'b0, 3'b011, 32'hCAFE0002, 32'h90,       4'd4));
    apply(mk(4'b0101, 32'h50,       32'h0,        4'd7, 1'b0, 32'h0,        3'b110, 1'b0, 3'b000, 32'hCAFE0002, 32'h90,       4'd4));
    v = mk(4'b0101, 32'h50,         32'h0,        4'd7, 1'b0, 32'h0,        3'b110, 1'b0, 3'b000, 32'h0,        32'h0,        4'd0);
    v.chk_w = 1'b0;
    apply(v);

    // Reset pulse while the load is waiting
    @(negedge clk);
    #1 reset_n = 1'b0;
    #1;
    chk("midrst_ctrl_w", {29'd0, PCSrcW, RegWriteW, MemtoRegW}, 32'd0);
    chk("midrst_rdata",  ReadDataW, 32'd0);
    chk("midrst_aluout", AluOutW, 32'd0);
    chk("midrst_wa3",    {28'd0, WA3W}, 32'd0);
    chk("midrst_fault",  {31'd0, mem_fault}, 32'd0);
    clear_inputs();
    #1;
    chk("midrst_req",    {31'd0, dmem_req}, 32'd0);
    chk("midrst_stall",  {31'd0, StallM}, 32'd0);
    #1 reset_n = 1'b1;

    apply(mk(4'b0100, 32'h2000,     32'h0,        4'd9, 1'b0, 32'h0,        3'b000, 1'b0, 3'b010, 32'h0,        32'h2000,     4'd9));
    apply(mk(4'b0101, 32'h70,       32'h0,        4'd10,1'b1, 32'h0BADF00D, 3'b010, 1'b0, 3'b011, 32'h0BADF00D, 32'h70,       4'd10));
`ifdef MEM_TIMEOUT_EN
    for (int i = 0; i < 5; i++)
      apply(mk(4'b0101, 32'h60,     32'h0,        4'd8, 1'b0, 32'h0,        3'b110, 1'b0, 3'b000, 32'h0BADF00D, 32'h70,       4'd10));
    apply(mk(4'b0101, 32'h60,       32'h0,        4'd8, 1'b0, 32'h0,        3'b000, 1'b1, 3'b000, 32'h0BADF00D, 32'h70,       4'd10));
    apply(mk(4'b0100, 32'h3000,     32'h0,        4'd11,1'b0, 32'h0,        3'b000, 1'b1, 3'b010, 32'h0BADF00D, 32'h3000,     4'd11));
    apply(mk(4'b0000, 32'h0,        32'h0,        4'd0, 1'b0, 32'h0,        3'b000, 1'b1, 3'b000, 32'h0BADF00D, 32'h0,        4'd0));
`endif
    apply(mk(4'b0000, 32'h0,        32'h0,        4'd0, 1'b0, 32'h0,        3'b000, `ifdef MEM_TIMEOUT_EN 1'b1 `else 1'b0 `endif, 3'b000, 32'h0BADF00D, 32'h0, 4'd0));

    for (int i = 0; i < 20 && (q.size() > 0 || pend_valid); i++) @(negedge clk);
    #1;
    chk("drain", q.size() + {31'd0, pend_valid}, 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
